// File: rtl/denise_bplshift_n.sv
// Bitplane serialiser: per-plane holding registers, odd/even scroll-delayed
// parallel load into MSB-first shifters, one serial bit per plane per pixel.
module denise_bplshift_n #(
  parameter int NPLANES = 8,
  parameter int MAXW    = 64,
  parameter int SCRW    = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clk7_en,
  input  logic               clk14_en,
  input  logic               hires,
  input  logic               shres,
  input  logic [1:0]         fmode,
  input  logic               wr_en,
  input  logic [2:0]         wr_plane,
  input  logic [MAXW-1:0]    wr_data,
  input  logic [SCRW-1:0]    scroll_odd,
  input  logic [SCRW-1:0]    scroll_even,
  output logic [NPLANES-1:0] bpldata,
  output logic               load_odd,
  output logic               load_even
);

  localparam logic [1:0] WLOG_MAX = 2'($clog2(MAXW / 16));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    LOAD  = 2'd2
  } grp_state_t;

  // Left-align a W-bit fetch word so its first pixel sits at bit MAXW-1.
  function automatic logic [MAXW-1:0] align_fetch(input logic [MAXW-1:0] d,
                                                  input logic [1:0]      wl);
    int w;
    w = 16 << wl;
    return d << (MAXW - w);
  endfunction

  logic                sh_en;
  logic                arm;
  logic [1:0]          wlog;
  logic [MAXW-1:0]     hold_p0  [NPLANES];
  logic [MAXW-1:0]     src      [NPLANES];
  logic [MAXW-1:0]     shift_p1 [NPLANES];
  grp_state_t          state_q  [2];
  grp_state_t          state_d  [2];
  logic [SCRW-1:0]     cnt_q    [2];
  logic [SCRW-1:0]     cnt_d    [2];
  logic [SCRW-1:0]     scroll_g [2];
  logic [1:0]          load_go;

  always_comb begin
    sh_en       = shres ? 1'b1 : (hires ? clk14_en : clk7_en);
    arm         = wr_en && (wr_plane == 3'd0);
    wlog        = (fmode > WLOG_MAX) ? WLOG_MAX : fmode;
    scroll_g[0] = scroll_odd;
    scroll_g[1] = scroll_even;
  end

  // Stage p0: BPLxDAT holding registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NPLANES; p++) hold_p0[p] <= '0;
    end else begin
      for (int p = 0; p < NPLANES; p++)
        if (wr_en && (wr_plane == 3'(p))) hold_p0[p] <= wr_data;
    end
  end

  // A load in the arming clk must see the plane-0 word written in that clk.
  always_comb begin
    for (int p = 0; p < NPLANES; p++)
      src[p] = (wr_en && (wr_plane == 3'(p))) ? wr_data : hold_p0[p];
  end

  // Group FSMs: index 0 = odd group (planes 0,2,..), 1 = even group
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int g = 0; g < 2; g++) begin
        state_q[g] <= IDLE;
        cnt_q[g]   <= '0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        state_q[g] <= state_d[g];
        cnt_q[g]   <= cnt_d[g];
      end
    end
  end

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      state_d[g] = state_q[g];
      cnt_d[g]   = cnt_q[g];
      case (state_q[g])
        IDLE: begin
          if (arm && !load_go[g]) begin
            state_d[g] = COUNT;
            cnt_d[g]   = scroll_g[g];
          end
        end
        COUNT: begin
          if (arm) begin
            if (load_go[g]) state_d[g] = IDLE;
            else            cnt_d[g]   = scroll_g[g];
          end else if (cnt_q[g] == '0) begin
            state_d[g] = load_go[g] ? IDLE : LOAD;
          end else if (clk7_en) begin
            cnt_d[g] = cnt_q[g] - 1'b1;
          end
        end
        LOAD: begin
          if (arm) begin
            state_d[g] = COUNT;
            cnt_d[g]   = scroll_g[g];
          end else if (load_go[g]) begin
            state_d[g] = IDLE;
          end
        end
        default: state_d[g] = IDLE;
      endcase
    end
  end

  // Scroll counts lores pixels, but the load itself waits for a pixel slot.
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      load_go[g] = 1'b0;
      if (sh_en) begin
        case (state_q[g])
          IDLE:    load_go[g] = arm && (scroll_g[g] == '0);
          COUNT:   load_go[g] = arm ? (scroll_g[g] == '0) : (cnt_q[g] == '0);
          LOAD:    load_go[g] = 1'b1;
          default: load_go[g] = 1'b0;
        endcase
      end
    end
    load_odd  = load_go[0];
    load_even = load_go[1];
  end

  // Stage p1: pixel shifters, load wins over shift
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NPLANES; p++) shift_p1[p] <= '0;
    end else begin
      for (int p = 0; p < NPLANES; p++) begin
        if (load_go[p % 2])
          shift_p1[p] <= align_fetch(src[p], wlog);
        else if (sh_en)
          shift_p1[p] <= shift_p1[p] << 1;
      end
    end
  end

  always_comb begin
    bpldata = '0;
    for (int p = 0; p < NPLANES; p++) bpldata[p] = shift_p1[p][MAXW-1];
  end

endmodule

// File: tb/tb_denise_bplshift_n.sv
// Directed bench for denise_bplshift_n: reset, lores/hires/shres serialisation,
// scroll delay, re-arm, load/shift collision and reset mid-count.
module tb_denise_bplshift_n;
  localparam int NPLANES = 8;
  localparam int MAXW    = 64;
  localparam int SCRW    = 6;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               clk7_en, clk14_en, hires, shres;
  logic [1:0]         fmode;
  logic               wr_en;
  logic [2:0]         wr_plane;
  logic [MAXW-1:0]    wr_data;
  logic [SCRW-1:0]    scroll_odd, scroll_even;
  logic [NPLANES-1:0] bpldata;
  logic               load_odd, load_even;

  logic [1:0] phase;
  int n_pass  = 0;
  int n_total = 0;

  denise_bplshift_n #(.NPLANES(NPLANES), .MAXW(MAXW), .SCRW(SCRW)) dut (
    .clk(clk), .reset_n(reset_n), .clk7_en(clk7_en), .clk14_en(clk14_en),
    .hires(hires), .shres(shres), .fmode(fmode), .wr_en(wr_en),
    .wr_plane(wr_plane), .wr_data(wr_data), .scroll_odd(scroll_odd),
    .scroll_even(scroll_even), .bpldata(bpldata), .load_odd(load_odd),
    .load_even(load_even)
  );

  always #5 clk = ~clk;

  // Advance to the next negedge and set enables for the coming posedge.
  task automatic step();
    @(negedge clk);
    wr_en    = 1'b0;
    phase    = phase + 2'd1;
    clk7_en  = (phase == 2'd0);
    clk14_en = ~phase[0];
    #1;
  endtask

  task automatic do_write(input logic [2:0] pl, input logic [MAXW-1:0] d);
    wr_en    = 1'b1;
    wr_plane = pl;
    wr_data  = d;
    #1;
  endtask

  task automatic wait_phase(input logic [1:0] ph);
    do step(); while (phase != ph);
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_total++;
    if (bpldata !== '0) $display("FAIL reset_bpldata: got %0h expected 0", bpldata);
    else n_pass++;
    n_total++;
    if (load_odd !== 1'b0) $display("FAIL reset_load_odd: got %0b expected 0", load_odd);
    else n_pass++;
    n_total++;
    if (load_even !== 1'b0) $display("FAIL reset_load_even: got %0b expected 0", load_even);
    else n_pass++;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_lores();
    logic exp;
    hires = 0; shres = 0; fmode = 2'd0; scroll_odd = '0; scroll_even = '0;
    wait_phase(2'd1);
    do_write(3'd1, '0);
    step();
    do_write(3'd0, 64'h8001);
    n_total++;
    if ({load_odd, load_even} !== 2'b00)
      $display("FAIL lores_no_load_at_arm: got %b expected 00", {load_odd, load_even});
    else n_pass++;
    step();
    step();
    n_total++;
    if ({load_odd, load_even} !== 2'b11)
      $display("FAIL lores_load_at_tick: got %b expected 11", {load_odd, load_even});
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      repeat (4) step();
      exp = (i == 0) || (i == 15);
      n_total++;
      if (bpldata[0] !== exp)
        $display("FAIL lores_pixel_%0d: got %0b expected %0b", i, bpldata[0], exp);
      else n_pass++;
    end
  endtask

  task automatic test_scroll();
    int ev_cnt, od_cnt, ev_cyc, od_cyc, s;
    logic [1:0] exp;
    ev_cnt = 0; od_cnt = 0; ev_cyc = -1; od_cyc = -1;
    scroll_odd = 6'd3; scroll_even = 6'd0;
    wait_phase(2'd1);
    do_write(3'd1, 64'hFFFF);
    step();
    do_write(3'd0, 64'hFFFF);
    for (int cyc = 0; cyc < 106; cyc++) begin
      if (cyc > 0) step();
      if (load_even) begin ev_cnt++; ev_cyc = cyc; end
      if (load_odd)  begin od_cnt++; od_cyc = cyc; end
      if (cyc > 2 && ((cyc - 2) % 4) == 0) begin
        s = (cyc - 2) / 4 - 1;
        exp[1] = (s < 16);
        exp[0] = (s >= 3) && (s < 19);
        n_total++;
        if (bpldata[1:0] !== exp)
          $display("FAIL scroll_pixel_%0d: got %b expected %b", s, bpldata[1:0], exp);
        else n_pass++;
      end
    end
    n_total++;
    if (ev_cnt != 1 || ev_cyc != 2)
      $display("FAIL scroll_even_load: got %0d pulses at %0d expected 1 at 2", ev_cnt, ev_cyc);
    else n_pass++;
    n_total++;
    if (od_cnt != 1 || (od_cyc - ev_cyc) != 12)
      $display("FAIL scroll_odd_delay: got %0d pulses, %0d clk after even, expected 1 and 12",
               od_cnt, od_cyc - ev_cyc);
    else n_pass++;
  endtask

  task automatic test_hires_shres();
    logic exp;
    int k;
    hires = 1; shres = 0; fmode = 2'd2; scroll_odd = '0; scroll_even = '0;
    wait_phase(2'd0);
    do_write(3'd2, 64'hF000_0000_0000_0001);
    step();
    do_write(3'd0, '0);
    for (int cyc = 1; cyc <= 137; cyc++) begin
      step();
      if (cyc == 1) begin
        n_total++;
        if (load_odd !== 1'b1) $display("FAIL hires_load: got %0b expected 1", load_odd);
        else n_pass++;
      end
      if (cyc >= 3 && ((cyc - 3) % 2) == 0) begin
        k = (cyc - 3) / 2;
        exp = (k < 4) || (k == 63);
        n_total++;
        if (bpldata[2] !== exp)
          $display("FAIL hires_pixel_%0d: got %0b expected %0b", k, bpldata[2], exp);
        else n_pass++;
      end
    end
    shres = 1;
    step();
    do_write(3'd0, '0);
    n_total++;
    if (load_odd !== 1'b1) $display("FAIL shres_load_in_arm_clk: got %0b expected 1", load_odd);
    else n_pass++;
    for (int i = 0; i < 68; i++) begin
      step();
      exp = (i < 4) || (i == 63);
      n_total++;
      if (bpldata[2] !== exp)
        $display("FAIL shres_pixel_%0d: got %0b expected %0b", i, bpldata[2], exp);
      else n_pass++;
    end
    hires = 0; shres = 0; fmode = 2'd0;
  endtask

  task automatic test_rearm();
    int od_cnt, od_cyc, ev_cnt;
    od_cnt = 0; od_cyc = -1; ev_cnt = 0;
    scroll_odd = 6'd5; scroll_even = 6'd0;
    wait_phase(2'd2);
    do_write(3'd0, '0);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      step();
      if (cyc == 8) do_write(3'd0, '0);
      if (cyc == 12) scroll_odd = 6'd1;
      if (load_odd)  begin od_cnt++; od_cyc = cyc; end
      if (load_even) ev_cnt++;
    end
    n_total++;
    if (od_cnt != 1 || od_cyc != 30)
      $display("FAIL rearm_odd_load: got %0d pulses at %0d expected 1 at 30", od_cnt, od_cyc);
    else n_pass++;
    n_total++;
    if (ev_cnt != 2) $display("FAIL rearm_even_loads: got %0d expected 2", ev_cnt);
    else n_pass++;
    scroll_odd = '0;
  endtask

  task automatic test_collision();
    logic [3:0] exp_px;
    exp_px = 4'b0011;
    scroll_odd = '0; scroll_even = '0;
    wait_phase(2'd1);
    do_write(3'd0, 64'hFFFF);
    wait_phase(2'd0);
    repeat (8) step();
    n_total++;
    if (bpldata[0] !== 1'b1) $display("FAIL collision_precondition: got %0b expected 1", bpldata[0]);
    else n_pass++;
    wait_phase(2'd2);
    do_write(3'd0, 64'hC000);
    step();
    step();
    n_total++;
    if (load_odd !== 1'b1) $display("FAIL collision_load: got %0b expected 1", load_odd);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      repeat (4) step();
      n_total++;
      if (bpldata[0] !== exp_px[k])
        $display("FAIL collision_pixel_%0d: got %0b expected %0b", k, bpldata[0], exp_px[k]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int nloads, nz;
    nloads = 0; nz = 0;
    scroll_odd = '0; scroll_even = '0;
    wait_phase(2'd1);
    do_write(3'd1, 64'hFFFF);
    step();
    do_write(3'd0, 64'hFFFF);
    step();
    step();
    step();
    scroll_odd = 6'd10; scroll_even = 6'd10;
    do_write(3'd0, 64'hFFFF);
    step();
    step();
    n_total++;
    if (bpldata[1:0] !== 2'b11) $display("FAIL resetmid_precondition: got %b expected 11", bpldata[1:0]);
    else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_total++;
    if (bpldata !== '0) $display("FAIL resetmid_bpldata: got %0h expected 0", bpldata);
    else n_pass++;
    n_total++;
    if ({load_odd, load_even} !== 2'b00)
      $display("FAIL resetmid_loads: got %b expected 00", {load_odd, load_even});
    else n_pass++;
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (load_odd || load_even) nloads++;
      if (bpldata != '0) nz++;
    end
    n_total++;
    if (nloads != 0 || nz != 0)
      $display("FAIL resetmid_after_release: got %0d loads %0d nonzero clks expected 0 0", nloads, nz);
    else n_pass++;
  endtask

  initial begin
    reset_n = 1'b0; phase = 2'd3; clk7_en = 0; clk14_en = 0; hires = 0; shres = 0;
    fmode = 2'd0; wr_en = 0; wr_plane = 3'd0; wr_data = '0;
    scroll_odd = '0; scroll_even = '0;
    test_reset();
    test_lores();
    test_scroll();
    test_hires_shres();
    test_rearm();
    test_collision();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
